// File: rtl/spi_target_if.sv
// Bus-side register access port of the SPI target (6502-style addr/data/rw/cs strobe).
interface spi_target_if;
  logic [3:0] addr;
  logic [7:0] data;
  logic       rw;
  logic       cs;
  logic [7:0] data_out;
  logic       data_out_en;

  modport master (output addr, data, rw, cs, input data_out, data_out_en);
  modport slave  (input addr, data, rw, cs, output data_out, data_out_en);
endinterface

// File: rtl/spi_target.sv
// SPI mode-0 target with RX/TX byte buffers and a status register on the host bus.
// sck/mosi/ss_n are synchronised into clock_sys and all SPI activity is edge-detected there.
module spi_target #(
  parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
  input  logic        clock_sys,
  input  logic        reset,
  spi_target_if.slave bus,
  input  logic        sck,
  input  logic        mosi,
  input  logic        ss_n,
  output logic        miso,
  output logic        miso_oe,
  output logic        irq
);

  typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_e;

  state_e     state_q;
  logic [2:0] sck_q;
  logic [1:0] mosi_q;
  logic [2:0] ss_q;
  logic [1:0] sync_vld_q;
  logic       armed_q;
  logic [7:0] shift_q;
  logic [6:0] rxsh_q;
  logic [2:0] bitcnt_q;
  logic       byte_done_q;
  logic [7:0] rx_data_q;
  logic [7:0] tx_buf_q;
  logic       rx_full_q;
  logic       rx_ovr_q;
  logic       tx_full_q;
  logic       tx_und_q;
  logic       miso_q;
  logic       miso_oe_q;

  logic       sck_rise;
  logic       sck_fall;
  logic       ss_fall;
  logic       ss_rise;
  logic       mosi_s;
  logic [7:0] load_byte;
  logic [7:0] rx_byte;
  logic       wr_status;
  logic       wr_tx;
  logic       rd_rx;
  logic [7:0] status;

  // armed_q blocks a select that was already low when reset released; a clean high must be seen first.
  always_ff @(posedge clock_sys) begin
    if (reset) begin
      sck_q      <= 3'b000;
      mosi_q     <= 2'b00;
      ss_q       <= 3'b111;
      sync_vld_q <= 2'b00;
      armed_q    <= 1'b0;
    end else begin
      sck_q      <= {sck_q[1:0], sck};
      mosi_q     <= {mosi_q[0], mosi};
      ss_q       <= {ss_q[1:0], ss_n};
      sync_vld_q <= {sync_vld_q[0], 1'b1};
      armed_q    <= armed_q | (sync_vld_q[1] & ss_q[1]);
    end
  end

  assign sck_rise  = sck_q[1] & ~sck_q[2];
  assign sck_fall  = ~sck_q[1] & sck_q[2];
  assign ss_fall   = ~ss_q[1] & ss_q[2] & armed_q;
  assign ss_rise   = ss_q[1] & ~ss_q[2];
  assign mosi_s    = mosi_q[1];
  assign load_byte = tx_full_q ? tx_buf_q : IDLE_BYTE;
  assign rx_byte   = {rxsh_q, mosi_s};

  assign wr_status = ~bus.cs & ~bus.rw & (bus.addr == 4'd0);
  assign wr_tx     = ~bus.cs & ~bus.rw & (bus.addr == 4'd2);
  assign rd_rx     = ~bus.cs & bus.rw & (bus.addr == 4'd1);

  // Flag clears are written first so that any set later in the block takes priority.
  always_ff @(posedge clock_sys) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      shift_q     <= IDLE_BYTE;
      rxsh_q      <= 7'd0;
      bitcnt_q    <= 3'd0;
      byte_done_q <= 1'b0;
      rx_data_q   <= 8'h00;
      tx_buf_q    <= 8'h00;
      rx_full_q   <= 1'b0;
      rx_ovr_q    <= 1'b0;
      tx_full_q   <= 1'b0;
      tx_und_q    <= 1'b0;
      miso_q      <= 1'b1;
      miso_oe_q   <= 1'b0;
    end else begin
      if (wr_status && bus.data[2]) rx_ovr_q <= 1'b0;
      if (wr_status && bus.data[3]) tx_und_q <= 1'b0;
      if (rd_rx) rx_full_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          miso_oe_q <= 1'b0;
          miso_q    <= 1'b1;
          if (ss_fall) begin
            state_q     <= ST_SHIFT;
            bitcnt_q    <= 3'd0;
            byte_done_q <= 1'b0;
            miso_oe_q   <= 1'b1;
            shift_q     <= load_byte;
            miso_q      <= load_byte[7];
            if (tx_full_q) tx_full_q <= 1'b0;
            else           tx_und_q  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (ss_rise) begin
            state_q     <= ST_IDLE;
            miso_oe_q   <= 1'b0;
            miso_q      <= 1'b1;
            bitcnt_q    <= 3'd0;
            byte_done_q <= 1'b0;
          end else if (sck_rise) begin
            rxsh_q   <= {rxsh_q[5:0], mosi_s};
            bitcnt_q <= bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              rx_data_q   <= rx_byte;
              rx_full_q   <= 1'b1;
              byte_done_q <= 1'b1;
              if (rx_full_q && !rd_rx) rx_ovr_q <= 1'b1;
            end
          end else if (sck_fall) begin
            if (bitcnt_q != 3'd0) begin
              shift_q <= {shift_q[6:0], 1'b0};
              miso_q  <= shift_q[6];
            end else if (byte_done_q) begin
              byte_done_q <= 1'b0;
              shift_q     <= load_byte;
              miso_q      <= load_byte[7];
              if (tx_full_q) tx_full_q <= 1'b0;
              else           tx_und_q  <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      // A host TX write lands after any reload, so the new byte stays pending.
      if (wr_tx) begin
        tx_buf_q  <= bus.data;
        tx_full_q <= 1'b1;
      end
    end
  end

  assign status = {3'b000, (state_q == ST_SHIFT), tx_und_q, rx_ovr_q, tx_full_q, rx_full_q};

  // Read mux is combinational from addr.
  always_comb begin
    bus.data_out = 8'h00;
    case (bus.addr)
      4'd0:    bus.data_out = status;
      4'd1:    bus.data_out = rx_data_q;
      4'd2:    bus.data_out = tx_buf_q;
      default: bus.data_out = 8'h00;
    endcase
  end

  assign bus.data_out_en = ~bus.cs & bus.rw;
  assign miso            = miso_q;
  assign miso_oe         = miso_oe_q;
  assign irq             = rx_full_q;

endmodule

// File: tb/tb_spi_target.sv
// Randomised bench for spi_target: the bench is the SPI initiator and the host, and a
// transaction-level model of buffers and flags predicts every read and every MISO byte.
module tb_spi_target;
  localparam logic [7:0] IDLE_BYTE = 8'hFF;

  logic clk = 1'b0;
  logic rst;
  logic sck, mosi, ss_n;
  logic miso, miso_oe, irq;

  spi_target_if bus_if ();

  spi_target #(.IDLE_BYTE(IDLE_BYTE)) dut (
    .clock_sys(clk),
    .reset    (rst),
    .bus      (bus_if),
    .sck      (sck),
    .mosi     (mosi),
    .ss_n     (ss_n),
    .miso     (miso),
    .miso_oe  (miso_oe),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [7:0] m_tx_buf, m_rx_data, m_cur;
  logic       m_tx_full, m_tx_und, m_rx_full, m_rx_ovr, m_sel, m_armed;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 8'h%02h expected 8'h%02h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_status();
    return {3'b000, m_sel, m_tx_und, m_rx_ovr, m_tx_full, m_rx_full};
  endfunction

  task automatic m_reset();
    m_tx_buf = 8'h00; m_rx_data = 8'h00; m_cur = IDLE_BYTE;
    m_tx_full = 1'b0; m_tx_und = 1'b0; m_rx_full = 1'b0; m_rx_ovr = 1'b0;
    m_sel = 1'b0; m_armed = ss_n;
  endtask

  // Next byte for the initiator: pending TX byte, or the idle byte with an underrun.
  task automatic m_load();
    if (m_tx_full) begin
      m_cur = m_tx_buf; m_tx_full = 1'b0;
    end else begin
      m_cur = IDLE_BYTE; m_tx_und = 1'b1;
    end
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [7:0] d);
    bus_if.cs = 1'b0; bus_if.rw = 1'b0; bus_if.addr = a; bus_if.data = d;
    @(negedge clk);
    bus_if.cs = 1'b1; bus_if.rw = 1'b1;
    if (a == 4'd0) begin
      if (d[2]) m_rx_ovr = 1'b0;
      if (d[3]) m_tx_und = 1'b0;
    end else if (a == 4'd2) begin
      m_tx_buf = d; m_tx_full = 1'b1;
    end
  endtask

  task automatic bus_rd(input logic [3:0] a, output logic [7:0] v);
    bus_if.cs = 1'b0; bus_if.rw = 1'b1; bus_if.addr = a;
    #1;
    v = bus_if.data_out;
    chk("data_out_en_rd", {7'd0, bus_if.data_out_en}, 8'h01);
    @(negedge clk);
    bus_if.cs = 1'b1;
    if (a == 4'd1) m_rx_full = 1'b0;
  endtask

  task automatic chk_status(input string tag);
    logic [7:0] v, e;
    e = m_status();
    chk("irq", {7'd0, irq}, {7'd0, m_rx_full});
    bus_rd(4'd0, v);
    chk(tag, v, e);
  endtask

  task automatic chk_rx(input string tag);
    logic [7:0] v, e;
    e = m_rx_data;
    bus_rd(4'd1, v);
    chk(tag, v, e);
  endtask

  task automatic frame_begin();
    ss_n = 1'b0;
    m_sel = m_armed;
    if (m_sel) m_load();
    repeat (6) @(negedge clk);
  endtask

  task automatic frame_end();
    repeat (4) @(negedge clk);
    ss_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("miso_oe_off", {7'd0, miso_oe}, 8'h00);
    m_sel = 1'b0; m_armed = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // Sends nbits of mo at sck = clk/8. mode 1: RXDATA read on the clock the byte lands;
  // mode 2: STATUS checked while sck is still high after the 8th rise.
  task automatic spi_byte(input logic [7:0] mo, input int nbits, input int mode);
    logic [7:0] got, exp, mask, rdv, old_rx;
    logic       sel;
    got = 8'h00; exp = m_cur; sel = m_sel; old_rx = m_rx_data; rdv = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[7-i];
      repeat (4) @(negedge clk);
      got[7-i] = miso;
      chk("miso_oe", {7'd0, miso_oe}, {7'd0, sel});
      sck = 1'b1;
      if (i == 7 && sel) begin
        if (mode == 1) begin
          repeat (2) @(negedge clk);
          bus_if.cs = 1'b0; bus_if.rw = 1'b1; bus_if.addr = 4'd1;
          #1 rdv = bus_if.data_out;
          @(negedge clk);
          bus_if.cs = 1'b1;
          chk("rd_at_set", rdv, old_rx);
          m_rx_data = mo; m_rx_full = 1'b1;
          @(negedge clk);
        end else begin
          repeat (3) @(negedge clk);
          if (m_rx_full) m_rx_ovr = 1'b1;
          m_rx_data = mo; m_rx_full = 1'b1;
          if (mode == 2) chk_status("status_at_byte");
          else @(negedge clk);
        end
      end else begin
        repeat (4) @(negedge clk);
      end
      sck = 1'b0;
    end
    if (sel) begin
      mask = 8'hFF << (8 - nbits);
      chk("miso_bits", got & mask, exp & mask);
      if (nbits == 8) m_load();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] v;
    rst = 1'b1; sck = 1'b0; mosi = 1'b0; ss_n = 1'b1;
    bus_if.cs = 1'b1; bus_if.rw = 1'b1; bus_if.addr = 4'd0; bus_if.data = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_reset();
    chk("rst_miso", {7'd0, miso}, 8'h01);
    chk("rst_miso_oe", {7'd0, miso_oe}, 8'h00);
    chk_status("rst_status");
    chk_rx("rst_rxdata");
    bus_rd(4'd2, v);
    chk("rst_txbuf", v, m_tx_buf);
    repeat (4) @(negedge clk);

    // Single byte exchange
    bus_wr(4'd2, 8'hA5);
    frame_begin();
    spi_byte(8'h3C, 8, 2);
    frame_end();
    chk_status("t1_status_end");
    chk_rx("t1_rxdata");

    // Two bytes, one TX write: underrun and overrun
    bus_wr(4'd2, 8'h81);
    frame_begin();
    spi_byte(8'($urandom), 8, 0);
    spi_byte(8'($urandom), 8, 2);
    frame_end();
    chk_status("t2_status");

    // Flag clear, unmapped reads, bus enable
    bus_wr(4'd0, 8'h0C);
    chk_status("t5_status");
    for (int a = 3; a < 16; a++) begin
      bus_rd(4'(a), v);
      chk("unmapped_rd", v, 8'h00);
    end
    bus_if.rw = 1'b1; bus_if.cs = 1'b1;
    #1 chk("data_out_en_idle", {7'd0, bus_if.data_out_en}, 8'h00);
    @(negedge clk);

    // Aborted partial byte, then a clean 8'h55
    chk_rx("t3_pre_rx");
    frame_begin();
    spi_byte(8'($urandom), 5, 0);
    frame_end();
    chk_status("t3_status_partial");
    frame_begin();
    spi_byte(8'h55, 8, 0);
    frame_end();
    chk_rx("t3_rx55");

    // RXDATA read on the clock a new byte lands (RX_FULL already set beforehand)
    frame_begin();
    spi_byte(8'($urandom), 8, 0);
    frame_end();
    bus_wr(4'd0, 8'h0C);
    frame_begin();
    spi_byte(8'($urandom), 8, 1);
    frame_end();
    chk_status("t4_status");
    chk_rx("t4_rx_new");

    // Reset in the middle of a byte with the select still low
    bus_wr(4'd2, 8'($urandom));
    frame_begin();
    spi_byte(8'($urandom), 8, 0);
    spi_byte(8'($urandom), 4, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_miso", {7'd0, miso}, 8'h01);
    chk("t6_miso_oe", {7'd0, miso_oe}, 8'h00);
    chk("t6_irq", {7'd0, irq}, 8'h00);
    rst = 1'b0;
    m_reset();
    chk_status("t6_status_rst");
    chk_rx("t6_rx_rst");
    spi_byte(8'($urandom), 4, 0);
    spi_byte(8'($urandom), 8, 0);
    chk_status("t6_status_ignored");
    frame_end();
    frame_begin();
    spi_byte(8'($urandom), 8, 2);
    frame_end();
    chk_rx("t6_rx_new");

    // Random frames
    for (int it = 0; it < 8; it++) begin
      int nb;
      if ($urandom_range(1, 0) == 1) bus_wr(4'd2, 8'($urandom));
      nb = int'($urandom_range(3, 1));
      frame_begin();
      for (int b = 0; b < nb; b++) spi_byte(8'($urandom), 8, ($urandom_range(1, 0) == 1) ? 2 : 0);
      frame_end();
      chk_status("rnd_status");
      if ($urandom_range(1, 0) == 1) chk_rx("rnd_rx");
      if ($urandom_range(2, 0) == 0) bus_wr(4'd0, 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
